// File: rtl/alu_instr_sequencer.sv
// Plays a host-written program of 15-bit instruction words to the ALU decode FSM:
// each word gets one load cycle (mode=0), then HOLD_CYCLES execute cycles (mode=1).
module alu_instr_sequencer #(
  parameter int DEPTH = 8,
  parameter int HOLD_CYCLES = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [14:0]   wr_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          stall,
  output logic [14:0]   dataOut,
  output logic          mode,
  output logic          busy,
  output logic          done,
  output logic          bad_op,
  output logic [AW-1:0] step_idx
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ZERO = (AW+1)'(0);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_t;

  function automatic logic op_ok(input logic [2:0] op);
    case (op)
      3'b010, 3'b011: op_ok = 1'b0;
      default:        op_ok = 1'b1;
    endcase
  endfunction

  state_t        state_r, state_s;
  logic [14:0]   mem_r [DEPTH];
  logic [AW-1:0] ptr_r, ptr_s, step_s;
  logic [AW:0]   len_r, len_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [14:0]   data_s, word_s;
  logic          mode_s, bad_s, busy_s, done_s;
  logic          idle_s, wr_ok_s, last_s;

  assign idle_s  = (state_r == IDLE) || (state_r == DONE);
  assign wr_ok_s = wr_en && idle_s;
  assign last_s  = ({1'b0, ptr_r} == (len_r - (AW+1)'(1)));

  // Program memory, host-writable only while not playing
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 15'd0;
    end else if (wr_ok_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) state_s = (prog_len == LEN_ZERO) ? DONE : LOAD;
        else       state_s = IDLE;
      end
      LOAD: state_s = stall ? LOAD : HOLD;
      HOLD: begin
        if (!stall && (cnt_r == CNT_LAST)) state_s = last_s ? DONE : LOAD;
        else                               state_s = HOLD;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output and datapath next values; a same-cycle write is forwarded to the first load
  always_comb begin
    len_s  = len_r;
    bad_s  = bad_op;
    data_s = dataOut;
    step_s = step_idx;
    mode_s = 1'b1;
    if (idle_s && start && (prog_len != LEN_ZERO)) begin
      ptr_s = AW'(0);
      len_s = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
      bad_s = 1'b0;
    end else if ((state_r == HOLD) && (state_s == LOAD)) begin
      ptr_s = ptr_r + AW'(1);
    end else begin
      ptr_s = ptr_r;
    end
    if (state_r == HOLD) cnt_s = stall ? cnt_r : (cnt_r + CW'(1));
    else                 cnt_s = CW'(0);
    word_s = (wr_ok_s && (wr_addr == ptr_s)) ? wr_data : mem_r[ptr_s];
    if ((state_s == LOAD) && (state_r != LOAD)) begin
      data_s = word_s;
      step_s = ptr_s;
      mode_s = ~op_ok(word_s[2:0]);
      bad_s  = bad_s | ~op_ok(word_s[2:0]);
    end else if ((state_r == LOAD) && stall) begin
      mode_s = mode;
    end else begin
      mode_s = 1'b1;
    end
    busy_s = (state_s == LOAD) || (state_s == HOLD);
    done_s = (state_s == DONE);
  end

  // Registered outputs and playback counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r    <= AW'(0);
      len_r    <= LEN_ZERO;
      cnt_r    <= CW'(0);
      dataOut  <= 15'd0;
      mode     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      bad_op   <= 1'b0;
      step_idx <= AW'(0);
    end else begin
      ptr_r    <= ptr_s;
      len_r    <= len_s;
      cnt_r    <= cnt_s;
      dataOut  <= data_s;
      mode     <= mode_s;
      busy     <= busy_s;
      done     <= done_s;
      bad_op   <= bad_s;
      step_idx <= step_s;
    end
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench: the driver queues expected load/done events, a negedge monitor checks them.
module tb_alu_instr_sequencer;
  localparam int H = 4;
  localparam int P = 1 + H;

  logic clock = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0, stall = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [14:0] wr_data = 15'd0;
  logic [3:0] prog_len = 4'd0;
  logic [14:0] dataOut;
  logic mode, busy, done, bad_op;
  logic [2:0] step_idx;

  alu_instr_sequencer #(.DEPTH(8), .HOLD_CYCLES(H)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .prog_len(prog_len), .stall(stall), .dataOut(dataOut), .mode(mode),
    .busy(busy), .done(done), .bad_op(bad_op), .step_idx(step_idx));

  always #5 clock = ~clock;

  typedef struct {bit is_done; int pe; logic [14:0] data; logic mode; int step; logic bad;} exp_t;
  exp_t q[$];
  int pe = 0, total = 0, passed = 0;
  logic [14:0] model [8];
  logic sticky_bad = 1'b0;
  logic prev_busy = 1'b0;
  logic [2:0] prev_step = 3'd0;

  always @(posedge clock) pe <= pe + 1;

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, pe);
  endtask

  task automatic ev(input bit is_done);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      $display("FAIL unexpected_event: got done=%0d at cycle %0d expected none", is_done, pe);
      return;
    end
    e = q.pop_front();
    chk("event_kind", is_done, e.is_done);
    chk("event_cycle", pe, e.pe);
    chk("bad_op", bad_op, e.bad);
    if (!is_done) begin
      chk("dataOut", dataOut, e.data);
      chk("mode", mode, e.mode);
      chk("step_idx", step_idx, e.step);
    end
  endtask

  // Monitor: a new presentation starts when busy rises or step_idx moves
  always @(negedge clock) begin
    if (!reset) begin
      if (done) ev(1'b1);
      if (busy && (!prev_busy || step_idx != prev_step)) ev(1'b0);
    end
    prev_busy = busy;
    prev_step = step_idx;
  end

  task automatic write(input int a, input logic [14:0] d);
    @(negedge clock);
    wr_en = 1'b1; wr_addr = a[2:0]; wr_data = d; model[a] = d;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic play(input int len, input int stall_n, input int abort_n, input bit inj,
                      input bit wr0, input logic [14:0] wr0_data);
    int k, l, tot, ep;
    logic bv, opbad;
    exp_t e;
    @(negedge clock);
    if (wr0) begin wr_en = 1'b1; wr_addr = 3'd0; wr_data = wr0_data; model[0] = wr0_data; end
    start = 1'b1; prog_len = len[3:0];
    k = pe + 1;
    l = (len > 8) ? 8 : len;
    bv = (len == 0) ? sticky_bad : 1'b0;
    for (int n = 0; n < l; n++) begin
      ep = k + n * P + ((n >= 1) ? stall_n : 0);
      opbad = (model[n][2:0] == 3'b010) || (model[n][2:0] == 3'b011);
      bv = bv | opbad;
      e = '{1'b0, ep, model[n], opbad, n, bv};
      if (abort_n == 0 || ep < k + abort_n) q.push_back(e);
    end
    if (abort_n == 0) begin
      e = '{1'b1, k + l * P + ((l > 0) ? stall_n : 0), 15'd0, 1'b1, 0, bv};
      q.push_back(e);
    end
    tot = k + l * P + stall_n + 3;
    @(negedge clock);
    start = 1'b0; wr_en = 1'b0;
    while (pe < tot) begin
      if (len == 0 && pe == k) begin chk("len0_busy", busy, 0); chk("len0_mode", mode, 1); end
      if (stall_n > 0 && pe == k + 1) stall = 1'b1;
      if (stall_n > 0 && pe == k + 1 + stall_n) stall = 1'b0;
      if (abort_n > 0 && pe == k + abort_n) begin
        reset = 1'b1; #1;
        chk("abort_mode", mode, 1); chk("abort_data", dataOut, 0); chk("abort_busy", busy, 0);
      end
      if (abort_n > 0 && pe == k + abort_n + 1) reset = 1'b0;
      if (inj && pe == k + 2) begin
        start = 1'b1; prog_len = 4'd2; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 15'h7FF;
      end
      if (inj && pe == k + 3) begin start = 1'b0; wr_en = 1'b0; end
      @(negedge clock);
    end
    chk("queue_drained", q.size(), 0);
    q.delete();
    if (abort_n > 0) begin
      sticky_bad = 1'b0;
      for (int i = 0; i < 8; i++) model[i] = 15'd0;
    end else begin
      sticky_bad = bv;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 15'd0;
    repeat (2) @(negedge clock);
    chk("rst_data", dataOut, 0); chk("rst_mode", mode, 1); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_bad", bad_op, 0); chk("rst_step", step_idx, 0);
    reset = 1'b0;
    // basic three-word program
    write(0, 15'h0A8); write(1, 15'h051); write(2, 15'h0E6);
    play(3, 0, 0, 1'b0, 1'b0, 15'd0);
    // empty program
    play(0, 0, 0, 1'b0, 1'b0, 15'd0);
    // unsupported opcode in slot 1
    write(1, 15'h012);
    play(3, 0, 0, 1'b0, 1'b0, 15'd0);
    // stall during the hold of word 0
    write(1, 15'h051);
    play(3, 3, 0, 1'b0, 1'b0, 15'd0);
    // reset during the hold of word 1, then replay cleared slot 0
    play(3, 0, 7, 1'b0, 1'b0, 15'd0);
    play(1, 0, 0, 1'b0, 1'b0, 15'd0);
    // over-long length, ignored start/write while busy, write forwarded at start
    for (int i = 1; i < 8; i++) write(i, 15'((i << 5) | 3'b101));
    play(15, 0, 0, 1'b1, 1'b1, 15'h4A1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
